// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: issues sequential word requests to instruction memory,
// buffers in-order responses with their PCs, and presents {pc, instr} to decode.
// A redirect restarts fetch at a new PC and discards every stale in-flight word.
module if_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] drop_nxt;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   head_pc;
  logic [31:0]   head_instr;

  logic          credit_ok;
  logic          accept;
  logic          rsp_eff;
  logic          push;
  logic          pop;
  logic [31:0]   redirect_base;
  logic [CW-1:0] outstanding_dec;

  // Handshake qualifiers; a response with nothing outstanding (e.g. just after reset) is ignored
  always_comb begin
    credit_ok       = ((CW+1)'(fifo_count) + (CW+1)'(outstanding)) < (CW+1)'(DEPTH);
    imem_req_valid  = reset & ~redirect_valid & credit_ok;
    imem_req_addr   = fetch_pc;
    accept          = imem_req_valid & imem_req_ready;
    rsp_eff         = imem_rsp_valid & (outstanding != '0);
    push            = rsp_eff & ~redirect_valid & (state == RUN);
    pop             = (fifo_count != '0) & out_ready & ~redirect_valid;
    redirect_base   = {redirect_pc[31:2], 2'b00};
    outstanding_dec = outstanding - CW'(rsp_eff);
    out_valid       = (fifo_count != '0);
    out_pc          = head_pc;
    out_instr       = head_instr;
  end

  // Drain FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      drop_cnt <= '0;
    end else begin
      state    <= state_nxt;
      drop_cnt <= drop_nxt;
    end
  end

  // Drain FSM next state: redirect reloads the stale-word count, DRAIN counts it down
  always_comb begin
    state_nxt = state;
    drop_nxt  = drop_cnt;
    if (redirect_valid) begin
      drop_nxt  = outstanding_dec;
      state_nxt = (outstanding_dec == '0) ? RUN : DRAIN;
    end else if ((state == DRAIN) && rsp_eff) begin
      drop_nxt = drop_cnt - CW'(1);
      if (drop_cnt == CW'(1)) begin
        state_nxt = RUN;
      end
    end
  end

  // Fetch/response PCs and in-flight request count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
    end else begin
      outstanding <= outstanding_dec + CW'(accept);
      if (redirect_valid) begin
        fetch_pc <= redirect_base;
        rsp_pc   <= redirect_base;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (push)   rsp_pc   <= rsp_pc + 32'd4;
      end
    end
  end

  // FIFO storage array
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= rsp_pc;
      instr_mem[wr_ptr] <= imem_rsp_data;
    end
  end

  // FIFO pointers, occupancy and registered head copy (held when the FIFO empties)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_count <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      head_pc    <= '0;
      head_instr <= '0;
    end else if (redirect_valid) begin
      fifo_count <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (pop) begin
        if (fifo_count > CW'(1)) begin
          head_pc    <= pc_mem[rd_ptr + PW'(1)];
          head_instr <= instr_mem[rd_ptr + PW'(1)];
        end else if (push) begin
          head_pc    <= rsp_pc;
          head_instr <= imem_rsp_data;
        end
      end else if ((fifo_count == '0) && push) begin
        head_pc    <= rsp_pc;
        head_instr <= imem_rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue against a transaction-queue reference model.
module tb_if_fetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready = 1'b0;

  if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Reference model: requests in flight (with stale marks) and buffered PCs
  typedef struct packed { logic [31:0] pc; logic stale; } infl_t;
  infl_t       m_infl[$];
  logic [31:0] m_fifo[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_last_pc;
  logic [31:0] m_last_instr;

  // Memory behavioural model: in-order responses after a random latency
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  int    cyc = 0;

  int          p_redir, p_rdy, p_out, max_lat;
  bit          force_redir = 0;
  logic [31:0] forced_pc;
  bit          ghost = 0;
  int          n_pop = 0;

  task automatic model_reset();
    m_infl.delete();
    m_fifo.delete();
    mq.delete();
    m_fetch_pc   = 32'h0;
    m_last_pc    = 32'h0;
    m_last_instr = 32'h0;
  endtask

  task automatic step();
    logic exp_req;
    logic acc;
    logic rsp;
    infl_t e;
    @(negedge clk);
    cyc++;
    redirect_valid = force_redir || ($urandom_range(99) < p_redir);
    if (force_redir) redirect_pc = forced_pc;
    else if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(15));
    else redirect_pc = 32'($urandom_range(4095));
    force_redir    = 0;
    imem_req_ready = ($urandom_range(99) < p_rdy);
    out_ready      = ($urandom_range(99) < p_out);
    if (ghost) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = $urandom;
      ghost          = 0;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    exp_req = !redirect_valid && ((m_fifo.size() + m_infl.size()) < DEPTH);
    check("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (exp_req) check("req_addr", imem_req_addr, m_fetch_pc);
    check("out_valid", 32'(out_valid), 32'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) begin
      m_last_pc    = m_fifo[0];
      m_last_instr = mem_word(m_fifo[0]);
    end
    check("out_pc", out_pc, m_last_pc);
    check("out_instr", out_instr, m_last_instr);
    if (out_valid && out_ready) n_pop++;
    // memory accepts what the DUT actually requested
    if (imem_req_valid && imem_req_ready) begin
      mreq_t r;
      r.addr = imem_req_addr;
      r.due  = cyc + $urandom_range(1, max_lat);
      mq.push_back(r);
    end
    // advance model across the coming edge
    acc = exp_req && imem_req_ready;
    rsp = imem_rsp_valid && (m_infl.size() != 0);
    if (redirect_valid) begin
      if (rsp) void'(m_infl.pop_front());
      foreach (m_infl[i]) m_infl[i].stale = 1'b1;
      m_fifo.delete();
      m_fetch_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (m_fifo.size() != 0 && out_ready) void'(m_fifo.pop_front());
      if (rsp) begin
        e = m_infl.pop_front();
        if (!e.stale) m_fifo.push_back(e.pc);
      end
      if (acc) begin
        e.pc    = m_fetch_pc;
        e.stale = 1'b0;
        m_infl.push_back(e);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
  endtask

  task automatic run(input int n, input int pr, input int prdy, input int pout, input int lat);
    p_redir = pr; p_rdy = prdy; p_out = pout; max_lat = lat;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    out_ready      = 1'b0;
    #1;
    model_reset();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ghost = 1;
  endtask

  initial begin
    do_reset();
    // sequential stream, 1-cycle memory
    run(20, 0, 100, 100, 1);
    // decode stalled, then resumes
    run(10, 0, 100, 0, 1);
    run(10, 0, 100, 100, 1);
    // memory stalled
    run(3, 0, 0, 100, 1);
    run(10, 0, 100, 100, 2);
    // misaligned redirect target with traffic in flight
    force_redir = 1; forced_pc = 32'h0000_0203;
    run(12, 0, 100, 100, 3);
    force_redir = 1; forced_pc = 32'h0000_0100;
    run(12, 0, 100, 50, 3);
    // address wrap
    force_redir = 1; forced_pc = 32'hFFFF_FFF4;
    run(12, 0, 100, 100, 1);
    // heavy random mix
    run(400, 6, 60, 60, 3);
    // sustained throughput
    run(12, 0, 100, 100, 1);
    n_pop = 0;
    run(30, 0, 100, 100, 1);
    check("throughput", 32'(n_pop), 32'd30);
    // reset mid-stream
    do_reset();
    run(60, 5, 70, 70, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
